// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the unified memory port:
// access sizes, arbiter states and lane geometry.
package riscv_mem_pkg;

  localparam int LANE_BYTES = 8;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_I = 2'b01,
    BUSY_D = 2'b10,
    RESP   = 2'b11
  } arb_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane placement for data accesses: strobes,
// lane-shifted store data and misalignment flag.
import riscv_mem_pkg::*;

module mem_lane_align #(
  parameter int DATA_W = 64
) (
  input  logic [1:0]            size,
  input  logic [2:0]            addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [LANE_BYTES-1:0] wstrb,
  output logic [DATA_W-1:0]     wdataSh,
  output logic                  misalign
);

  always_comb begin
    wstrb    = '0;
    misalign = 1'b0;
    unique case (1'b1)
      (size == SZ_B): begin
        wstrb = 8'h01 << addr;
      end
      (size == SZ_H): begin
        wstrb    = 8'h03 << addr;
        misalign = addr[0];
      end
      (size == SZ_W): begin
        wstrb    = 8'h0F << addr;
        misalign = |addr[1:0];
      end
      default: begin
        wstrb    = 8'hFF;
        misalign = |addr;
      end
    endcase
  end

  assign wdataSh = wdata << {addr, 3'b000};

endmodule

// File: rtl/unified_mem_arbiter.sv
// Fetch/data arbiter for the single-ported memory,
// with fetch-starvation guard and stale-fetch dropping.
import riscv_mem_pkg::*;

module unified_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 64,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_flush,
  output logic              i_valid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wstrb,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  arb_state_e state, nextState;

  logic [SW-1:0]     streak;
  logic              drop;
  logic              respI;
  logic              errQ;
  logic              weQ;
  logic [ADDR_W-1:2] addrQ;
  logic [7:0]        strbQ;
  logic [DATA_W-1:0] wdataQ;
  logic [DATA_W-1:0] dRdataQ;
  logic [31:0]       iRdataQ;

  logic              iCand, atMax, dWin, iWin, busy;
  logic [7:0]        laneStrb;
  logic [DATA_W-1:0] laneWdata;
  logic              misalign;
  logic              unusedIAddr;

  assign unusedIAddr = ^i_addr[1:0];

  mem_lane_align #(
    .DATA_W (DATA_W)
  ) uAlign (
    .size     (d_size),
    .addr     (d_addr[2:0]),
    .wdata    (d_wdata),
    .wstrb    (laneStrb),
    .wdataSh  (laneWdata),
    .misalign (misalign)
  );

  // Data wins by default; a full streak hands the slot to fetch.
  assign iCand = i_req & ~i_flush;
  assign atMax = (streak == STREAK_MAX);
  assign dWin  = (state == IDLE) & d_req & ~(iCand & atMax);
  assign iWin  = (state == IDLE) & iCand & ~dWin;
  assign busy  = (state == BUSY_I) | (state == BUSY_D);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    mem_req   = busy;
    mem_we    = busy & weQ;
    mem_addr  = '0;
    mem_wstrb = '0;
    mem_wdata = '0;
    i_valid   = 1'b0;
    d_done    = 1'b0;
    d_err     = 1'b0;
    if (busy) begin
      mem_addr  = {addrQ[ADDR_W-1:3], 3'b000};
      mem_wstrb = strbQ;
      mem_wdata = wdataQ;
    end
    case (state)
      IDLE: begin
        if (dWin)      nextState = misalign ? RESP : BUSY_D;
        else if (iWin) nextState = BUSY_I;
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready) nextState = RESP;
      end
      RESP: begin
        nextState = IDLE;
        i_valid   = respI & ~drop & ~i_flush;
        d_done    = ~respI;
        d_err     = ~respI & errQ;
      end
      default: nextState = IDLE;
    endcase
  end

  assign i_rdata = iRdataQ;
  assign d_rdata = dRdataQ;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak  <= '0;
      drop    <= 1'b0;
      respI   <= 1'b0;
      errQ    <= 1'b0;
      weQ     <= 1'b0;
      addrQ   <= '0;
      strbQ   <= '0;
      wdataQ  <= '0;
      dRdataQ <= '0;
      iRdataQ <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (iWin || !i_req)      streak <= '0;
          else if (dWin && !atMax) streak <= streak + 1'b1;
          if (dWin) begin
            respI  <= 1'b0;
            errQ   <= misalign;
            weQ    <= d_we;
            addrQ  <= d_addr[ADDR_W-1:2];
            strbQ  <= d_we ? laneStrb : 8'h00;
            wdataQ <= laneWdata;
          end else if (iWin) begin
            respI  <= 1'b1;
            errQ   <= 1'b0;
            weQ    <= 1'b0;
            addrQ  <= i_addr[ADDR_W-1:2];
            strbQ  <= '0;
            wdataQ <= '0;
          end
        end
        BUSY_I: begin
          if (i_flush) drop <= 1'b1;
          if (mem_ready)
            iRdataQ <= addrQ[2] ? mem_rdata[32 +: 32]
                                : mem_rdata[0 +: 32];
        end
        BUSY_D: begin
          if (mem_ready) dRdataQ <= mem_rdata;
        end
        default: begin
          drop <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomized bench for unified_mem_arbiter against a
// transaction-level arbitration and lane-placement model.
module tb_unified_mem_arbiter;

  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_flush = 1'b0;
  logic        i_valid;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [1:0]  d_size = '0;
  logic [31:0] d_addr = '0;
  logic [63:0] d_wdata = '0;
  logic        d_done;
  logic        d_err;
  logic [63:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wstrb;
  logic [63:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic [63:0] mem_rdata = '0;

  int total = 0;
  int bad = 0;
  int mStreak = 0;

  unified_mem_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (64),
    .MAX_D_STREAK (MAXS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_flush   (i_flush),
    .i_valid   (i_valid),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_size    (d_size),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_done    (d_done),
    .d_err     (d_err),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wstrb (mem_wstrb),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One arbitration slot: drive requests, predict the winner,
  // act as the memory and check the response.
  task automatic doRound(
    input bit          ir,
    input bit          dr,
    input bit          fl,
    input bit          we,
    input logic [1:0]  sz,
    input logic [31:0] da,
    input logic [63:0] wd,
    input logic [31:0] ia,
    input int          dly,
    input bit          fb,
    input bit          fr,
    input logic [63:0] rd
  );
    int win;
    int bytes;
    int sh;
    bit mis;
    bit expV;
    logic [63:0] msk;
    logic [63:0] eStrb;
    logic [63:0] eWd;
    logic [31:0] eAddr;
    bytes = 1 << sz;
    msk = (bytes == 8) ? '1 : ((64'd1 << (8 * bytes)) - 1);
    wd = wd & msk;
    sh = da % 8;
    win = 0;
    if (dr && !(ir && !fl && mStreak == MAXS)) win = 2;
    else if (ir && !fl) win = 1;
    if (win == 1 || !ir) mStreak = 0;
    else if (win == 2 && mStreak < MAXS) mStreak++;
    mis = (win == 2) && (da % bytes != 0);
    eStrb = 0;
    if (win == 2 && we) eStrb = ((64'd1 << bytes) - 1) << sh;
    eStrb = eStrb & 64'hFF;
    eWd = (wd << (8 * sh));
    eAddr = (win == 1) ? (ia & ~32'd7) : (da & ~32'd7);
    i_req = ir; d_req = dr; i_flush = fl;
    d_we = we; d_size = sz; d_addr = da;
    d_wdata = wd; i_addr = ia;
    step();
    i_flush = 1'b0;
    if (win == 0) begin
      chk("idle_mreq", mem_req, 0);
      chk("idle_done", {i_valid, d_done}, 0);
      return;
    end
    if (mis) begin
      chk("mis_mreq", mem_req, 0);
      chk("mis_done", {d_done, d_err}, 2'b11);
      step();
      return;
    end
    expV = (win == 1);
    for (int c = 0; c <= dly; c++) begin
      chk("busy_mreq", mem_req, 1);
      chk("busy_addr", mem_addr, eAddr);
      chk("busy_we", mem_we, (win == 2) && we);
      chk("busy_strb", mem_wstrb, eStrb);
      if (win == 2 && we) chk("busy_wdata", mem_wdata, eWd);
      i_flush = fb && (c == 0);
      if (i_flush && win == 1) expV = 0;
      mem_ready = (c == dly);
      mem_rdata = (c == dly) ? rd : 64'h0;
      step();
    end
    mem_ready = 1'b0;
    i_flush = fr;
    if (fr) expV = 0;
    #1;
    chk("resp_ivalid", i_valid, expV);
    chk("resp_done", {d_done, d_err}, {(win == 2), 1'b0});
    if (expV)
      chk("resp_irdata", i_rdata, (rd >> (32 * ia[2])) & 64'hFFFF_FFFF);
    if (win == 2 && !we) chk("resp_drdata", d_rdata, rd);
    i_flush = 1'b0;
    step();
  endtask

  initial begin
    #12;
    chk("rst_mreq", mem_req, 0);
    chk("rst_outs", {i_valid, d_done, d_err, mem_we, mem_wstrb}, 0);
    chk("rst_data", {i_rdata, d_rdata[31:0]}, 0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // Lone fetch, upper word of the line
    doRound(1, 0, 0, 0, 2'd0, 0, 0, 32'h104, 0, 0, 0,
            64'hAAAA_BBBB_1111_2222);
    // Byte store races a fetch; fetch follows
    doRound(1, 1, 0, 1, 2'd0, 32'h203, 64'hEE, 32'h1000, 0, 0, 0, 0);
    doRound(1, 0, 0, 0, 2'd0, 0, 0, 32'h1000, 0, 0, 0,
            64'h1234_5678_9ABC_DEF0);
    // Sustained data traffic against a waiting fetch
    for (int k = 0; k < 6; k++)
      doRound(1, 1, 0, 0, 2'd3, 32'h2000, 0, 32'h1008, 0, 0, 0,
              {$urandom, $urandom});
    // Redirect while the fetch is in flight
    doRound(1, 0, 0, 0, 2'd0, 0, 0, 32'h1100, 3, 1, 0,
            64'h5555_6666_7777_8888);
    // Misaligned word load
    doRound(0, 1, 0, 0, 2'd2, 32'h102, 0, 0, 0, 0, 0, 0);
    // Flush in the same cycle a data request is granted
    doRound(0, 1, 1, 1, 2'd1, 32'h2006, 64'hBEEF, 0, 1, 1, 1, 0);

    for (int n = 0; n < 250; n++)
      doRound($urandom % 2, $urandom % 2, ($urandom % 5) == 0,
              $urandom % 2, 2'($urandom % 4),
              32'h2000 + ($urandom % 64),
              {$urandom, $urandom},
              32'h1000 + 4 * ($urandom % 256),
              $urandom % 4, ($urandom % 4) == 0,
              ($urandom % 6) == 0, {$urandom, $urandom});

    // Reset while a data access is outstanding
    i_req = 1'b0; d_req = 1'b1; d_we = 1'b0;
    d_size = 2'd3; d_addr = 32'h2040;
    step();
    chk("rst6_busy", mem_req, 1);
    i_req = 1'b1;
    rst = 1'b0;
    #1;
    chk("rst6_mreq", mem_req, 0);
    chk("rst6_outs", {i_valid, d_done, mem_wstrb}, 0);
    d_req = 1'b0;
    mStreak = 0;
    @(negedge clk);
    rst = 1'b1;
    doRound(1, 0, 0, 0, 2'd0, 0, 0, 32'h1200, 1, 0, 0,
            64'hCAFE_F00D_0BAD_BEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
